// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : shares one uart_tx byte transmitter between NUM_REQ
// valid/ready requesters, with message locking and round-robin fairness.
// Rev 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_WAIT    = 4,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             uart_data,
  output logic                   uart_write_en,
  input  logic                   uart_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [BW-1:0] C_BUSY_LAST = BW'((BUSY_WAIT > 0) ? BUSY_WAIT - 1 : 0);
  localparam logic [LW-1:0] C_LOCK_LAST = LW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_locked;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_rr;
  logic [BW-1:0]       r_busy_cnt;
  logic [LW-1:0]       r_lock_cnt;

  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [IW-1:0]       w_idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Locked: only the owner is eligible. Otherwise scan from the rr pointer;
  // iterating downward lets the lowest offset from r_rr win.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    if (r_locked) begin
      w_found = req_valid[r_owner];
      w_win   = r_owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = IW'((int'(r_rr) + k) % NUM_REQ);
        if (req_valid[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ARB;
      r_locked      <= 1'b0;
      r_owner       <= '0;
      r_rr          <= '0;
      r_busy_cnt    <= '0;
      r_lock_cnt    <= '0;
      req_ready     <= '0;
      grant         <= '0;
      uart_data     <= 8'h00;
      uart_write_en <= 1'b0;
    end else begin
      uart_write_en <= 1'b0;
      req_ready     <= '0;
      case (r_state)
        ARB: begin
          if (!uart_busy && w_found) begin
            uart_data     <= req_data[8*w_win +: 8];
            uart_write_en <= 1'b1;
            req_ready     <= onehot(w_win);
            grant         <= onehot(w_win);
            r_busy_cnt    <= '0;
            r_lock_cnt    <= '0;
            r_state       <= WAIT_BUSY;
            if (req_last[w_win]) begin
              r_locked <= 1'b0;
              r_rr     <= next_idx(w_win);
            end else begin
              r_locked <= 1'b1;
              r_owner  <= w_win;
            end
          end else if (r_locked && !req_valid[r_owner] && (LOCK_TIMEOUT != 0)) begin
            // An owner that stops offering bytes eventually forfeits the lock.
            if (r_lock_cnt == C_LOCK_LAST) begin
              r_locked   <= 1'b0;
              r_rr       <= next_idx(r_owner);
              grant      <= '0;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
        end
        WAIT_BUSY: begin
          if (uart_busy || (r_busy_cnt == C_BUSY_LAST)) begin
            r_state <= WAIT_IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!uart_busy) begin
            r_state <= ARB;
            if (!r_locked) begin
              grant <= '0;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter with a simple
// uart_tx busy model and queue-driven requesters.
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int BUSY_WAIT    = 4;
  localparam int LOCK_TIMEOUT = 16;
  localparam int BUSY_LEN     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  uart_data;
  logic        uart_write_en;
  logic        uart_busy = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npulses = 0;
  int last_pulse = 0;
  int busy_cnt = 0;
  bit stuck = 1'b0;
  logic prev_we = 1'b0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] sb[$];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .BUSY_WAIT(BUSY_WAIT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .uart_data(uart_data), .uart_write_en(uart_write_en), .uart_busy(uart_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic last);
    if (r == 0) q0.push_back({last, d});
    else        q1.push_back({last, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    sb.push_back({r[0], d});
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int start;
    int i;
    start = npulses;
    i = 0;
    while (npulses == start && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_pulse_seen"}, 32'(npulses > start), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || uart_busy) && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_drained"}, 32'(sb.size() + q0.size() + q1.size()), 32'd0);
    tick(4);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Requesters hold each queued byte until ready; uart_busy rises after write_en.
  initial forever begin
    @(negedge clk);
    if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
    if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());
    req_valid[0]   = (q0.size() > 0);
    req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req_last[0]    = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    req_valid[1]   = (q1.size() > 0);
    req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req_last[1]    = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    if (uart_write_en) busy_cnt = BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    uart_busy = !stuck && (busy_cnt > 0);
  end

  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (prev_we) begin
      check("ready_one_cycle", 32'(req_ready), 32'd0);
      check("we_one_cycle", 32'(uart_write_en), 32'd0);
    end
    if (uart_write_en) begin
      if (npulses > 0) check("pulse_gap_min3", 32'(cyc - last_pulse >= 3), 32'd1);
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_byte observed=0x%0h expected=none", uart_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("uart_data", 32'(uart_data), 32'(e[7:0]));
        check("grant_at_issue", 32'(grant), 32'(2'b01 << e[8]));
        check("ready_at_issue", 32'(req_ready), 32'(2'b01 << e[8]));
      end
      npulses = npulses + 1;
      last_pulse = cyc;
    end
    prev_we = uart_write_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [10];
    int t0;
    int np;
    msg = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

    tick(2);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we", 32'(uart_write_en), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    rst = 1'b0;
    tick(2);

    // Reset while the UART is busy with a byte; rr was advanced to 1 before it.
    send(0, 8'h11, 1'b1); expect_byte(0, 8'h11);
    wait_pulse("t1a", 20);
    tick(3);
    check("t1_grant_pre_rst", 32'(grant), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_grant", 32'(grant), 32'd0);
    check("t1_async_data", 32'(uart_data), 32'd0);
    check("t1_async_we", 32'(uart_write_en), 32'd0);
    tick(1);
    rst = 1'b0;
    send(1, 8'h22, 1'b1); send(0, 8'h33, 1'b1);
    expect_byte(0, 8'h33); expect_byte(1, 8'h22);
    drain("t1", 200);

    // Both valid, unlocked: strict alternation.
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h30, 1'b1); send(1, 8'h31, 1'b1);
      expect_byte(0, 8'h30); expect_byte(1, 8'h31);
    end
    drain("t3", 400);

    // Locked multi-byte line from req0 must not be interleaved with req1.
    for (int i = 0; i < 10; i++) begin
      send(0, msg[i], (i == 9)); expect_byte(0, msg[i]);
    end
    send(1, 8'h55, 1'b1); expect_byte(1, 8'h55);
    drain("t4", 600);

    // Single byte, last=1: grant released once idle.
    send(0, 8'h41, 1'b1); expect_byte(0, 8'h41);
    wait_pulse("t2", 20);
    drain("t2", 100);
    check("t2_grant_released", 32'(grant), 32'd0);

    // Lock timeout. Issue edge E0; busy seen on E1..E10; ARB from E11;
    // 16 counted ARB edges E12..E27 drop the lock; req1 issues on E28.
    send(0, 8'h41, 1'b0); expect_byte(0, 8'h41);
    wait_pulse("t5a", 20);
    t0 = last_pulse;
    np = npulses;
    send(1, 8'h42, 1'b1); expect_byte(1, 8'h42);
    while (cyc < t0 + 20) tick(1);
    check("t5_locked_grant", 32'(grant), 32'h1);
    check("t5_no_early_issue", 32'(npulses), 32'(np));
    wait_pulse("t5b", 60);
    check("t5_latency", 32'(last_pulse - t0), 32'd28);
    drain("t5", 100);
    check("t5_grant_released", 32'(grant), 32'd0);

    // uart_busy never rises: BUSY_WAIT fallback paces bytes 6 cycles apart.
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, 8'h61 + 8'(i), 1'b1); expect_byte(0, 8'h61 + 8'(i));
    end
    wait_pulse("t6a", 20);
    t0 = last_pulse;
    wait_pulse("t6b", 20);
    check("t6_gap1", 32'(last_pulse - t0), 32'd6);
    t0 = last_pulse;
    wait_pulse("t6c", 20);
    check("t6_gap2", 32'(last_pulse - t0), 32'd6);
    drain("t6", 100);
    stuck = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
